// File: rtl/arith_cmd_sequencer.sv
// arith_cmd_sequencer
// Buffers {op1, op2, op} commands in a small FIFO, drives the external
// combinational arithmetic unit one command at a time from registered
// operands, captures its result/overflow into a valid/ready output port,
// and keeps a saturating count of overflow events.
module arith_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op1,
  input  logic [7:0]       in_op2,
  input  logic [1:0]       in_op,
  output logic [7:0]       arith_op1,
  output logic [7:0]       arith_op2,
  output logic [1:0]       arith_op,
  input  logic [7:0]       arith_result,
  input  logic             arith_ov,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic             out_ov,
  output logic             out_err,
  output logic [CNT_W-1:0] ov_cnt,
  input  logic             ov_clr
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [17:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // FSM and registered outputs
  state_t           r_state;
  logic [7:0]       r_arith_op1;
  logic [7:0]       r_arith_op2;
  logic [1:0]       r_arith_op;
  logic             r_out_valid;
  logic [7:0]       r_out_result;
  logic             r_out_ov;
  logic             r_out_err;
  logic [CNT_W-1:0] r_ov_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_not_empty;
  logic [17:0]      w_head;

  assign in_ready    = (r_count < FULL_CNT);
  assign w_push      = in_valid && in_ready;
  assign w_not_empty = (r_count != '0);
  // A pop happens when the FSM is free to issue: idle, or handing off a result.
  assign w_pop       = w_not_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
  assign w_head      = r_mem[r_rd_ptr];

  assign arith_op1   = r_arith_op1;
  assign arith_op2   = r_arith_op2;
  assign arith_op    = r_arith_op;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_ov      = r_out_ov;
  assign out_err     = r_out_err;
  assign ov_cnt      = r_ov_cnt;

  // Command storage write port (contents need no reset; count gates reads)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_op1, in_op2, in_op};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue/capture FSM with registered unit operands and result port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_arith_op1  <= '0;
      r_arith_op2  <= '0;
      r_arith_op   <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ov     <= 1'b0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_arith_op1, r_arith_op2, r_arith_op} <= w_head;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_out_result <= arith_result;
          r_out_ov     <= arith_ov;
          r_out_err    <= (r_arith_op == 2'b11);
          r_out_valid  <= 1'b1;
          r_state      <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_pop) begin
              {r_arith_op1, r_arith_op2, r_arith_op} <= w_head;
              r_state <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating overflow-event counter; a clear beats a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ov_cnt <= '0;
    end else if (ov_clr) begin
      r_ov_cnt <= '0;
    end else if ((r_state == S_EXEC) && arith_ov && (r_ov_cnt != '1)) begin
      r_ov_cnt <= r_ov_cnt + 1'b1;
    end
  end

endmodule
